// File: rtl/game_pkg.sv
// Shared constants and the deal sequencer state encoding used across the game control blocks.
package game_pkg;

    localparam int CARD_NUM    = 106;
    localparam int IDX_W       = 7;
    localparam int CNT_W       = 4;
    localparam int INVALID_IDX = 110;
    localparam int HAND_DEAL   = 14;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        COMMIT,
        FIN
    } deal_state_e;

endpackage

// File: rtl/deal_cards.sv
// Deck owner and draw sequencer: requests one card at a time from draw_once and moves it deck -> hand.
// Optional build macro DEAL_CHECK_EN rejects out-of-range or already-dealt indices and redraws.
module deal_cards
    import game_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                interboard_rst,
    input  logic                deal_start,
    input  logic [CNT_W-1:0]    deal_cnt,
    input  logic                draw_ready,
    input  logic                draw_done,
    input  logic [IDX_W-1:0]    drawn_card_idx,
    output logic                draw_one,
    output logic [CARD_NUM-1:0] available_card,
    output logic [CARD_NUM-1:0] hand_card,
    output logic [IDX_W-1:0]    deck_left,
    output logic                card_valid,
    output logic [IDX_W-1:0]    card_idx,
    output logic                busy,
    output logic                deal_done,
    output logic                deck_empty
);

    deal_state_e         r_state;
    logic [CNT_W-1:0]    r_remain;
    logic [IDX_W-1:0]    r_drawn_idx;
    logic [CARD_NUM-1:0] r_avail;
    logic [CARD_NUM-1:0] r_hand;
    logic [IDX_W-1:0]    r_deck_left;
    logic                r_draw_one;
    logic                r_card_valid;
    logic [IDX_W-1:0]    r_card_idx;
    logic                r_deal_done;
    logic                r_deck_empty;

    logic                w_in_range;
    logic                w_accept;
    logic [CNT_W-1:0]    w_remain_next;

    assign w_in_range    = (r_drawn_idx < IDX_W'(CARD_NUM));
    assign w_remain_next = r_remain - 1'b1;

`ifdef DEAL_CHECK_EN
    logic [7:0] r_err_cnt;
    // A card may only be committed if it is a real tile that is still in the deck.
    assign w_accept = w_in_range && r_avail[r_drawn_idx];
`else
    assign w_accept = 1'b1;
`endif

    // NOTE: the bitmaps are plain flops, not a RAM, so they take the async reset like any other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_remain     <= '0;
            r_drawn_idx  <= IDX_W'(INVALID_IDX);
            r_avail      <= '1;
            r_hand       <= '0;
            r_deck_left  <= IDX_W'(CARD_NUM);
            r_draw_one   <= 1'b0;
            r_card_valid <= 1'b0;
            r_card_idx   <= '0;
            r_deal_done  <= 1'b0;
            r_deck_empty <= 1'b0;
`ifdef DEAL_CHECK_EN
            r_err_cnt    <= '0;
`endif
        end else if (interboard_rst) begin
            r_state      <= IDLE;
            r_remain     <= '0;
            r_drawn_idx  <= IDX_W'(INVALID_IDX);
            r_avail      <= '1;
            r_hand       <= '0;
            r_deck_left  <= IDX_W'(CARD_NUM);
            r_draw_one   <= 1'b0;
            r_card_valid <= 1'b0;
            r_card_idx   <= '0;
            r_deal_done  <= 1'b0;
            r_deck_empty <= 1'b0;
`ifdef DEAL_CHECK_EN
            r_err_cnt    <= '0;
`endif
        end else begin
            // NOTE: pulses default low here so every branch below only has to raise them.
            r_draw_one   <= 1'b0;
            r_card_valid <= 1'b0;
            r_deal_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (deal_start) begin
                        r_remain     <= deal_cnt;
                        r_deck_empty <= 1'b0;
                        r_state      <= (deal_cnt == '0) ? FIN : REQ;
                    end
                end
                REQ: begin
                    // draw_once divides by deck_left, so an empty deck must never be requested.
                    if (r_deck_left == '0) begin
                        r_deck_empty <= 1'b1;
                        r_state      <= FIN;
                    end else if (draw_ready) begin
                        r_draw_one <= 1'b1;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (draw_done) begin
                        r_drawn_idx <= drawn_card_idx;
                        r_state     <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (w_accept) begin
                        if (w_in_range) begin
                            r_avail[r_drawn_idx] <= 1'b0;
                            r_hand[r_drawn_idx]  <= 1'b1;
                        end
                        r_deck_left  <= r_deck_left - 1'b1;
                        r_remain     <= w_remain_next;
                        r_card_valid <= 1'b1;
                        r_card_idx   <= r_drawn_idx;
                        r_state      <= (w_remain_next == '0) ? FIN : REQ;
                    end else begin
`ifdef DEAL_CHECK_EN
                        r_err_cnt <= r_err_cnt + 1'b1;
`endif
                        r_state   <= REQ;
                    end
                end
                FIN: begin
                    r_deal_done <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign draw_one       = r_draw_one;
    assign available_card = r_avail;
    assign hand_card      = r_hand;
    assign deck_left      = r_deck_left;
    assign card_valid     = r_card_valid;
    assign card_idx       = r_card_idx;
    assign busy           = (r_state != IDLE);
    assign deal_done      = r_deal_done;
    assign deck_empty     = r_deck_empty;

endmodule

// File: tb/tb_deal_cards.sv
// Table-driven bench for deal_cards with a behavioural draw_once responder that hands out the lowest free tile.
module tb_deal_cards;
    import game_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                interboard_rst;
    logic                deal_start;
    logic [CNT_W-1:0]    deal_cnt;
    logic                draw_ready;
    logic                draw_done;
    logic [IDX_W-1:0]    drawn_card_idx;
    logic                draw_one;
    logic [CARD_NUM-1:0] available_card;
    logic [CARD_NUM-1:0] hand_card;
    logic [IDX_W-1:0]    deck_left;
    logic                card_valid;
    logic [IDX_W-1:0]    card_idx;
    logic                busy;
    logic                deal_done;
    logic                deck_empty;

    deal_cards dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .deal_start     (deal_start),
        .deal_cnt       (deal_cnt),
        .draw_ready     (draw_ready),
        .draw_done      (draw_done),
        .drawn_card_idx (drawn_card_idx),
        .draw_one       (draw_one),
        .available_card (available_card),
        .hand_card      (hand_card),
        .deck_left      (deck_left),
        .card_valid     (card_valid),
        .card_idx       (card_idx),
        .busy           (busy),
        .deal_done      (deal_done),
        .deck_empty     (deck_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit poke;
        int ready_hold;
        int exp_draws;
        int exp_cards;
        int exp_left;
        bit exp_empty;
        int exp_hand;
    } row_t;

    int total = 0;
    int bad   = 0;

    logic [CARD_NUM-1:0] m_deck;
    logic [CARD_NUM-1:0] m_hand;
    int m_left;
    int exp_q[$];
    int script_q[$];
    int n_draws, n_cards, n_done, zero_draws, resp_cnt;
    bit resp_hold;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick();
        for (int i = 0; i < CARD_NUM; i++)
            if (m_deck[i]) return i;
        return INVALID_IDX;
    endfunction

    task automatic reset_model();
        m_deck = '1;
        m_hand = '0;
        m_left = CARD_NUM;
        exp_q.delete();
        script_q.delete();
    endtask

    task automatic clear_counts();
        n_draws = 0; n_cards = 0; n_done = 0; zero_draws = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_avail"},      available_card, {CARD_NUM{1'b1}});
        check({tag, "_hand"},       hand_card, '0);
        check({tag, "_deck_left"},  deck_left, CARD_NUM);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_draw_one"},   draw_one, 0);
        check({tag, "_card_valid"}, card_valid, 0);
        check({tag, "_deal_done"},  deal_done, 0);
        check({tag, "_deck_empty"}, deck_empty, 0);
        check({tag, "_card_idx"},   card_idx, 0);
    endtask

    // Monitor: sampled 1 time unit after the active edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (draw_one) begin
            n_draws++;
            if (m_left == 0) zero_draws++;
        end
        if (card_valid) begin
            n_cards++;
            if (exp_q.size() > 0) check("card_idx", card_idx, exp_q.pop_front());
            else                  check("card_idx_unexpected", card_idx, 'x);
        end
        if (deal_done) n_done++;
    end

    // draw_once stand-in: answers each draw_one after 1..3 cycles.
    initial forever begin
        int idx;
        @(posedge clk);
        #1;
        if (draw_one && !resp_hold) begin
            repeat (1 + resp_cnt % 3) @(negedge clk);
            resp_cnt++;
            if (script_q.size() > 0) begin
                idx = script_q.pop_front();
`ifndef DEAL_CHECK_EN
                exp_q.push_back(idx);
                m_left--;
`endif
            end else begin
                idx = pick();
                if (idx < CARD_NUM) begin
                    m_deck[idx] = 1'b0;
                    m_hand[idx] = 1'b1;
                    m_left--;
                end
                exp_q.push_back(idx);
            end
            draw_done      = 1'b1;
            drawn_card_idx = IDX_W'(idx);
            @(negedge clk);
            draw_done = 1'b0;
        end
    end

    task automatic run_row(input row_t r, input int k);
        int cycles;
        string t;
        t = $sformatf("row%0d", k);
        clear_counts();
        if (r.ready_hold > 0) draw_ready = 1'b0;
        deal_cnt   = CNT_W'(r.cnt);
        deal_start = 1'b1;
        @(negedge clk);
        deal_start = 1'b0;
        cycles = 0;
        if (r.ready_hold > 0) begin
            repeat (r.ready_hold) @(negedge clk);
            check({t, "_no_draw_while_not_ready"}, n_draws, 0);
            draw_ready = 1'b1;
        end
        if (r.poke) begin
            while (n_draws == 0 && cycles < 50) begin
                @(negedge clk);
                cycles++;
            end
            deal_start = 1'b1;
            deal_cnt   = 4'd7;
            @(negedge clk);
            deal_start = 1'b0;
        end
        while (n_done == 0 && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        check({t, "_in_time"}, (cycles < 400), 1);
        if (r.cnt == 0) check({t, "_fast_done"}, (cycles <= 2), 1);
        repeat (6) @(negedge clk);
        check({t, "_deal_done_cnt"}, n_done, 1);
        check({t, "_draws"},         n_draws, r.exp_draws);
        check({t, "_cards"},         n_cards, r.exp_cards);
        check({t, "_zero_draws"},    zero_draws, 0);
        check({t, "_deck_left"},     deck_left, r.exp_left);
        check({t, "_deck_empty"},    deck_empty, r.exp_empty);
        check({t, "_avail"},         available_card, m_deck);
        check({t, "_hand"},          hand_card, m_hand);
        check({t, "_hand_pop"},      $countones(hand_card), r.exp_hand);
        check({t, "_busy"},          busy, 0);
    endtask

    row_t rows[11];
    row_t extra;
    int   c;

    initial begin
        rst = 1'b0; interboard_rst = 1'b0; deal_start = 1'b0; deal_cnt = '0;
        draw_ready = 1'b1; draw_done = 1'b0; drawn_card_idx = '0;
        resp_hold = 1'b0; resp_cnt = 0;
        reset_model();
        clear_counts();

        rows[0]  = '{14, 0, 0, 14, 14, 92, 0, 14};
        rows[1]  = '{ 0, 0, 0,  0,  0, 92, 0, 14};
        rows[2]  = '{ 3, 1, 0,  3,  3, 89, 0, 17};
        rows[3]  = '{15, 0, 5, 15, 15, 74, 0, 32};
        rows[4]  = '{15, 0, 0, 15, 15, 59, 0, 47};
        rows[5]  = '{15, 0, 0, 15, 15, 44, 0, 62};
        rows[6]  = '{15, 0, 0, 15, 15, 29, 0, 77};
        rows[7]  = '{15, 0, 0, 15, 15, 14, 0, 92};
        rows[8]  = '{12, 0, 0, 12, 12,  2, 0, 104};
        rows[9]  = '{ 5, 0, 0,  2,  2,  0, 1, 106};
        rows[10] = '{ 1, 0, 0,  0,  0,  0, 1, 106};

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 11; k++) run_row(rows[k], k);

        // Async reset during the third card's WAIT; a late draw_done must not commit.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        reset_model();
        @(negedge clk);
        clear_counts();
        deal_cnt = 4'd5;
        deal_start = 1'b1;
        @(negedge clk);
        deal_start = 1'b0;
        c = 0;
        while (n_cards < 2 && c < 200) begin @(negedge clk); c++; end
        resp_hold = 1'b1;
        while (n_draws < 3 && c < 200) begin @(negedge clk); c++; end
        check("mid_reset_reached_wait", (c < 200), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_values("async");
        reset_model();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cards = 0;
        draw_done = 1'b1;
        drawn_card_idx = 7'd60;
        @(negedge clk);
        draw_done = 1'b0;
        resp_hold = 1'b0;
        repeat (5) @(negedge clk);
        check("late_done_cards", n_cards, 0);
        check_reset_values("late_done");

        // Synchronous interboard reset after a short deal.
        extra = '{2, 0, 0, 2, 2, 104, 0, 2};
        run_row(extra, 20);
        interboard_rst = 1'b1;
        @(negedge clk);
        check("ib_rst_avail", available_card, {CARD_NUM{1'b1}});
        interboard_rst = 1'b0;
        reset_model();
        check_reset_values("ib_rst");

        // Draw_once returns the invalid reset index first.
        script_q.push_back(INVALID_IDX);
`ifdef DEAL_CHECK_EN
        extra = '{1, 0, 0, 2, 1, 105, 0, 1};
        run_row(extra, 30);
        check("err_cnt", dut.r_err_cnt, 1);
`else
        extra = '{1, 0, 0, 1, 1, 105, 0, 0};
        run_row(extra, 30);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
